// File: rtl/button_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : button_mode_ctrl_if
// Description : Press input and LED/mode status bundle for button_mode_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
interface button_mode_ctrl_if;
    logic       button_pressed;
    logic       led;
    logic [1:0] mode;
    logic       press_accepted;

    // Master drives presses and observes status; slave is the controller.
    modport master (
        output button_pressed,
        input  led,
        input  mode,
        input  press_accepted
    );

    modport slave (
        input  button_pressed,
        output led,
        output mode,
        output press_accepted
    );
endinterface
`default_nettype wire

// File: rtl/button_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : button_mode_ctrl
// Description : Steps an LED through OFF/SLOW/FAST/ON on debounced presses.
// Revision    : 1.0  initial release
// ============================================================================
module button_mode_ctrl #(
    parameter int SLOW_HALF_CYCLES = 12_500_000,
    parameter int FAST_HALF_CYCLES = 2_500_000,
    parameter int DEBOUNCE_CYCLES  = 5_000_000
) (
    input  wire                  clock,
    input  wire                  reset,
    button_mode_ctrl_if.slave    bus
);

    localparam int LOCK_W_RAW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LOCK_W      = (LOCK_W_RAW < 1) ? 1 : LOCK_W_RAW;
    localparam int HALF_MAX    = (SLOW_HALF_CYCLES > FAST_HALF_CYCLES) ?
                                 SLOW_HALF_CYCLES : FAST_HALF_CYCLES;
    localparam int BLINK_W_RAW = $clog2(HALF_MAX);
    localparam int BLINK_W     = (BLINK_W_RAW < 1) ? 1 : BLINK_W_RAW;

    localparam logic [LOCK_W-1:0]  c_LOCK_LOAD = LOCK_W'(DEBOUNCE_CYCLES);
    localparam logic [BLINK_W-1:0] c_SLOW_LAST = BLINK_W'(SLOW_HALF_CYCLES - 1);
    localparam logic [BLINK_W-1:0] c_FAST_LAST = BLINK_W'(FAST_HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2,
        ST_ON   = 2'd3
    } mode_t;

    mode_t              r_state;
    logic               r_led;
    logic               r_press_accepted;
    logic [LOCK_W-1:0]  r_lock_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;

    logic               w_accept;
    mode_t              w_next_state;
    logic [BLINK_W-1:0] w_blink_last;

    // Presses during the lockout window are discarded, not queued.
    assign w_accept = bus.button_pressed && (r_lock_cnt == '0);

    always_comb begin
        w_next_state = ST_OFF;
        case (r_state)
            ST_OFF:  w_next_state = ST_SLOW;
            ST_SLOW: w_next_state = ST_FAST;
            ST_FAST: w_next_state = ST_ON;
            ST_ON:   w_next_state = ST_OFF;
            default: w_next_state = ST_OFF;
        endcase
    end

    assign w_blink_last = (r_state == ST_FAST) ? c_FAST_LAST : c_SLOW_LAST;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= ST_OFF;
            r_led            <= 1'b0;
            r_press_accepted <= 1'b0;
            r_lock_cnt       <= '0;
            r_blink_cnt      <= '0;
        end else begin
            r_press_accepted <= w_accept;

            if (w_accept) begin
                r_state     <= w_next_state;
                r_lock_cnt  <= c_LOCK_LOAD;
                r_blink_cnt <= '0;
                // Every mode but OFF is entered lit, so blinking starts on.
                r_led       <= (w_next_state != ST_OFF);
            end else begin
                if (r_lock_cnt != '0) begin
                    r_lock_cnt <= r_lock_cnt - 1'b1;
                end

                case (r_state)
                    ST_SLOW, ST_FAST: begin
                        if (r_blink_cnt == w_blink_last) begin
                            r_blink_cnt <= '0;
                            r_led       <= ~r_led;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_blink_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.led            = r_led;
    assign bus.mode           = r_state;
    assign bus.press_accepted = r_press_accepted;

endmodule
`default_nettype wire

// File: tb/tb_button_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_mode_ctrl
// Description : Directed self-checking bench for button_mode_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_button_mode_ctrl;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   pulse_cnt;

    button_mode_ctrl_if bus ();

    button_mode_ctrl #(
        .SLOW_HALF_CYCLES (8),
        .FAST_HALF_CYCLES (2),
        .DEBOUNCE_CYCLES  (5)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        bus.button_pressed = 1'b1;
        tick();
        bus.button_pressed = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        bus.button_pressed = 1'b1;

        // Reset held three cycles with the button asserted throughout.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_mode", 32'(bus.mode), 0);
            check_eq("rst_led", 32'(bus.led), 0);
            check_eq("rst_pa", 32'(bus.press_accepted), 0);
        end
        reset = 1'b0;
        bus.button_pressed = 1'b0;
        tick();
        check_eq("post_rst_mode", 32'(bus.mode), 0);
        check_eq("post_rst_pa", 32'(bus.press_accepted), 0);
        press();
        check_eq("first_press_mode", 32'(bus.mode), 1);
        check_eq("first_press_pa", 32'(bus.press_accepted), 1);

        // Slow blink: entered lit, toggles every 8 edges.
        check_eq("slow_entry_led", 32'(bus.led), 1);
        tick();
        check_eq("pa_one_cycle", 32'(bus.press_accepted), 0);
        ticks(6);
        check_eq("slow_k7_led", 32'(bus.led), 1);
        tick();
        check_eq("slow_k8_led", 32'(bus.led), 0);
        ticks(7);
        check_eq("slow_k15_led", 32'(bus.led), 0);
        tick();
        check_eq("slow_k16_led", 32'(bus.led), 1);

        // Five presses ten cycles apart walk the mode ring.
        do_reset();
        pulse_cnt = 0;
        for (int p = 0; p < 5; p++) begin
            logic [1:0] exp_mode;
            exp_mode = 2'((p + 1) % 4);
            press();
            if (bus.press_accepted) pulse_cnt++;
            check_eq("cyc_mode", 32'(bus.mode), 32'(exp_mode));
            check_eq("cyc_pa", 32'(bus.press_accepted), 1);
            check_eq("cyc_led_entry", 32'(bus.led), (exp_mode == 2'd0) ? 0 : 1);
            for (int i = 0; i < 9; i++) begin
                tick();
                if (bus.press_accepted) pulse_cnt++;
            end
        end
        check_eq("cyc_pulse_count", 32'(pulse_cnt), 5);

        // Lockout: only presses at k and k+6 are accepted.
        do_reset();
        press();
        check_eq("db_k_mode", 32'(bus.mode), 1);
        bus.button_pressed = 1'b1; tick();
        check_eq("db_k1_mode", 32'(bus.mode), 1);
        check_eq("db_k1_pa", 32'(bus.press_accepted), 0);
        bus.button_pressed = 1'b0; tick();
        bus.button_pressed = 1'b1; tick();
        check_eq("db_k3_mode", 32'(bus.mode), 1);
        bus.button_pressed = 1'b0; tick();
        bus.button_pressed = 1'b1; tick();
        check_eq("db_k5_mode", 32'(bus.mode), 1);
        check_eq("db_k5_pa", 32'(bus.press_accepted), 0);
        tick();
        bus.button_pressed = 1'b0;
        check_eq("db_k6_mode", 32'(bus.mode), 2);
        check_eq("db_k6_pa", 32'(bus.press_accepted), 1);

        // Fast blink from that entry: toggles every 2 edges.
        check_eq("fast_entry_led", 32'(bus.led), 1);
        tick();
        check_eq("fast_k1_led", 32'(bus.led), 1);
        tick();
        check_eq("fast_k2_led", 32'(bus.led), 0);
        ticks(2);
        check_eq("fast_k4_led", 32'(bus.led), 1);

        // Mid-period press from SLOW: counter clears and FAST starts lit.
        do_reset();
        press();
        ticks(8);
        check_eq("mid_slow_led", 32'(bus.led), 0);
        press();
        check_eq("mid_fast_mode", 32'(bus.mode), 2);
        check_eq("mid_fast_led", 32'(bus.led), 1);
        tick();
        check_eq("mid_fast_k1_led", 32'(bus.led), 1);
        tick();
        check_eq("mid_fast_k2_led", 32'(bus.led), 0);

        // Lockout is now 3; reset must clear it and all other state.
        reset = 1'b1;
        bus.button_pressed = 1'b1;
        tick();
        check_eq("mid_rst_mode", 32'(bus.mode), 0);
        check_eq("mid_rst_led", 32'(bus.led), 0);
        check_eq("mid_rst_pa", 32'(bus.press_accepted), 0);
        reset = 1'b0;
        tick();
        bus.button_pressed = 1'b0;
        check_eq("after_rst_mode", 32'(bus.mode), 1);
        check_eq("after_rst_pa", 32'(bus.press_accepted), 1);
        ticks(7);
        check_eq("after_rst_k7_led", 32'(bus.led), 1);
        tick();
        check_eq("after_rst_k8_led", 32'(bus.led), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_mode_ctrl.md
# button_mode_ctrl

Consumes the synchronized, single-cycle button-press pulse from the input-synchronization stage and drives one LED through four modes, advancing one mode per accepted press. It contains a lockout timer that rejects contact bounce, a four-state mode machine, and a half-period blink counter. It sits directly downstream of the synchronizer on the 50 MHz system clock; its outputs go to the board LED and to status logic.

## Interface
- SLOW_HALF_CYCLES, 12_500_000: clock cycles per LED half-period in slow blink (2 Hz at 50 MHz); legal range ≥ 1.
- FAST_HALF_CYCLES, 2_500_000: clock cycles per LED half-period in fast blink (10 Hz); legal range ≥ 1.
- DEBOUNCE_CYCLES, 5_000_000: lockout length after an accepted press (100 ms); legal range ≥ 0, where 0 disables lockout.
- clock  in  1  50 MHz system clock; all state updates on its rising edge.
- reset  in  1  Synchronous reset, active-high, sampled on the rising edge of clock.
- button_pressed  in  1  Single-cycle press pulse, already synchronized to clock.
- led  out  1  LED drive, registered.
- mode  out  2  Current mode, registered: 0 = OFF, 1 = SLOW, 2 = FAST, 3 = ON.
- press_accepted  out  1  One-cycle registered pulse marking an accepted press.

## Operation
- Reset (reset = 1 at an edge): mode = OFF, led = 0, press_accepted = 0, lockout counter = 0, blink counter = 0. Reset has priority over a simultaneous button_pressed.
- Acceptance: a press is accepted at an edge when button_pressed = 1, reset = 0 and the lockout counter = 0.
  - All other presses are dropped silently; they are neither queued nor counted.
- On an accepted press, at the same edge:
  - mode advances OFF→SLOW→FAST→ON→OFF; wrap-around is from ON to OFF.
  - The lockout counter loads DEBOUNCE_CYCLES.
  - press_accepted is set to 1 for exactly one cycle.
- Lockout counter: decrements by 1 each edge while non-zero and saturates at 0.
  - A reload always replaces the current value; it is never additive.
- Blink counter and led in SLOW and FAST modes, with HALF = SLOW_HALF_CYCLES or FAST_HALF_CYCLES by mode:
  - The counter counts 0..HALF-1.
  - At an edge where counter = HALF-1, led toggles and the counter wraps to 0.
  - Otherwise the counter increments.
- On any mode change, the blink counter clears to 0 and led takes its entry value for the new mode:
  - OFF: 0.
  - SLOW and FAST: 1; blinking always starts lit.
  - ON: 1.
- In OFF and ON, the blink counter is held at 0 and led is held constant.
- Counter widths: lockout uses $clog2(DEBOUNCE_CYCLES+1) bits, minimum 1. Blink uses $clog2(max(SLOW,FAST)) bits, minimum 1. Counters are unsigned and never wrap below 0.
- With HALF = 1, led toggles on every edge in that mode.

## Timing
- Press latency: for button_pressed high during the cycle before edge k, the following are all visible after edge k:
  - the new mode,
  - the new led entry value,
  - press_accepted = 1.
- press_accepted returns to 0 after edge k+1, unless another press is accepted at k+1, which is only possible with DEBOUNCE_CYCLES = 0.
- Lockout window: after acceptance at edge k, presses sampled at edges k+1..k+DEBOUNCE_CYCLES are ignored. The first press that can be accepted is at edge k+DEBOUNCE_CYCLES+1.
- Blink: after entry at edge k, led first toggles at edge k+HALF, then every HALF edges after that. Full period = 2·HALF cycles.
- Reset asserted mid-blink or mid-lockout: all state is cleared at that edge. The first press after reset deasserts is accepted immediately, with no lockout carried over.
- No combinational path from any input to any output.

## Test plan
- Parameters for all tests: SLOW_HALF_CYCLES = 8, FAST_HALF_CYCLES = 2, DEBOUNCE_CYCLES = 5.
- Reset: hold reset for 3 cycles with button_pressed = 1 throughout → mode = 0, led = 0, press_accepted = 0 during and after reset. The first press after release gives mode = 1.
- Mode cycling: 5 presses spaced 10 cycles apart → mode goes 1, 2, 3, 0, 1. press_accepted pulses exactly 5 times, each 1 cycle wide, at the same edge as the mode change.
- Debounce: press at edge k, then pulses at k+1, k+3, k+5, then k+6 → only k and k+6 accepted. mode goes 0→1→2.
- Blink timing: enter SLOW at edge k → led = 1 after edge k, 0 after k+8, 1 after k+16. In FAST, toggles after edges k+2, k+4 and so on. A press mid-period clears the counter and led = 1 on entry to FAST.
- Reset mid-operation: in FAST with lockout = 3, assert reset for 1 cycle → mode = 0, led = 0. A press one cycle after reset is accepted (mode = 1).
